// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: accepts a host key, starts the expander,
// captures the streamed round keys into a local file and serves 1-cycle reads.
//
// state    | meaning
// IDLE     | waiting for key_req with cipher engine not busy
// WAIT_RDY | key latched, waiting for expander idle to pulse km_init
// CAPTURE  | collecting round keys 0..NUM_ROUNDS in order, watchdog armed
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int WDOG_CYC   = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key_in,
  input  logic         key_req,
  output logic         key_ack,
  input  logic         cipher_busy,
  output logic [127:0] km_key,
  output logic         km_init,
  input  logic         km_ready,
  input  logic [3:0]   km_round,
  input  logic [127:0] km_roundkey,
  input  logic         km_roundkey_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         keys_valid,
  output logic         seq_err
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
  localparam logic [2:0] WDOG_LIM = 3'(WDOG_CYC);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, CAPTURE} state_t;

  state_t       state;
  logic [3:0]   exp_rnd;
  logic [2:0]   wdog;
  logic [127:0] mem [0:NUM_ROUNDS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      key_ack    <= 1'b0;
      km_init    <= 1'b0;
      km_key     <= '0;
      keys_valid <= 1'b0;
      seq_err    <= 1'b0;
      exp_rnd    <= '0;
      wdog       <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) mem[i] <= '0;
    end else begin
      key_ack <= 1'b0;
      km_init <= 1'b0;
      case (state)
        IDLE: begin
          if (key_req && !cipher_busy) begin
            km_key     <= key_in;
            key_ack    <= 1'b1;
            keys_valid <= 1'b0;
            seq_err    <= 1'b0;
            state      <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (km_ready) begin
            km_init <= 1'b1;
            exp_rnd <= '0;
            wdog    <= '0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (km_roundkey_valid) begin
            if (km_round == exp_rnd) begin
              mem[exp_rnd] <= km_roundkey;
              if (exp_rnd != LAST_RND) exp_rnd <= exp_rnd + 4'd1;
              if (km_round == LAST_RND) begin
                keys_valid <= 1'b1;
                state      <= IDLE;
              end
            end else begin
              seq_err <= 1'b1;
              state   <= IDLE;
            end
          end else if (exp_rnd != 4'd0) begin
            // stream stopped before the last round
            seq_err <= 1'b1;
            state   <= IDLE;
          end else if (wdog == WDOG_LIM - 3'd1) begin
            seq_err <= 1'b1;
            state   <= IDLE;
          end else if (wdog != 3'h7) begin
            wdog <= wdog + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_data <= '0;
    end else if (rk_addr <= LAST_RND) begin
      rk_data <= mem[rk_addr];
    end else begin
      rk_data <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: stimulus pushes timed expected
// events, a negedge monitor pops them as the DUT produces outputs.
module tb_aes_key_sched_ctrl;

  localparam int EV_ACK = 0, EV_INIT = 1, EV_KV_RISE = 2, EV_KV_FALL = 3,
                 EV_ERR_RISE = 4, EV_ERR_FALL = 5, EV_RD = 6;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] key_in;
  logic         key_req;
  logic         key_ack;
  logic         cipher_busy;
  logic [127:0] km_key;
  logic         km_init;
  logic         km_ready;
  logic [3:0]   km_round;
  logic [127:0] km_roundkey;
  logic         km_roundkey_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         keys_valid;
  logic         seq_err;

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .WDOG_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_req(key_req),
    .key_ack(key_ack), .cipher_busy(cipher_busy), .km_key(km_key),
    .km_init(km_init), .km_ready(km_ready), .km_round(km_round),
    .km_roundkey(km_roundkey), .km_roundkey_valid(km_roundkey_valid),
    .rk_addr(rk_addr), .rk_data(rk_data), .keys_valid(keys_valid),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rd_req = 1'b0;
  logic rd_vld_q = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_vld_q <= rd_req;
  end

  typedef struct {
    int           kind;
    int           cyc;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [127:0] mem_mdl [0:10];
  logic         mdl_kv = 1'b0;
  logic         mdl_err = 1'b0;
  int           last_t0 = 0;
  int           mode = 0;   // 0 nominal, 1 rounds 0,1,3, 2 silent, 3 nominal but aborted by reset
  int           skip_seq [3] = '{0, 1, 3};

  // FIPS-197 schedule for the FIPS key; other keys get a keyed variant
  function automatic logic [127:0] rk_of(input logic [127:0] k, input int r);
    return fips_rk[r] ^ k ^ FIPS_KEY;
  endfunction

  function automatic string ev_name(input int k);
    case (k)
      EV_ACK:      return "key_ack";
      EV_INIT:     return "km_init";
      EV_KV_RISE:  return "keys_valid_rise";
      EV_KV_FALL:  return "keys_valid_fall";
      EV_ERR_RISE: return "seq_err_rise";
      EV_ERR_FALL: return "seq_err_fall";
      default:     return "rk_data";
    endcase
  endfunction

  function automatic void push(input int kind, input int c, input logic [127:0] d);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    q.push_back(e);
  endfunction

  function automatic void push_load(input int t0, input logic [127:0] k, input int md, input int d);
    push(EV_ACK, t0 + 1, '0);
    if (mdl_kv)  push(EV_KV_FALL, t0 + 1, '0);
    if (mdl_err) push(EV_ERR_FALL, t0 + 1, '0);
    push(EV_INIT, t0 + 2 + d, k);
    mdl_kv  = 1'b0;
    mdl_err = 1'b0;
    case (md)
      0: begin
        push(EV_KV_RISE, t0 + 14 + d, '0);
        for (int r = 0; r <= 10; r++) mem_mdl[r] = rk_of(k, r);
        mdl_kv = 1'b1;
      end
      1: begin
        mem_mdl[0] = rk_of(k, 0);
        mem_mdl[1] = rk_of(k, 1);
        push(EV_ERR_RISE, t0 + 6 + d, '0);
        mdl_err = 1'b1;
      end
      2: begin
        push(EV_ERR_RISE, t0 + 6 + d, '0);
        mdl_err = 1'b1;
      end
      default: ;
    endcase
    last_t0 = t0;
  endfunction

  task automatic observe(input int kind, input logic [127:0] d);
    n_cmp++;
    if (q.size() > 0 && q[0].kind == kind && q[0].cyc == cyc) begin
      if ((kind == EV_INIT || kind == EV_RD) && d !== q[0].data) begin
        n_mis++;
        $display("FAIL %s_data at cycle %0d: got %h, required %h", ev_name(kind), cyc, d, q[0].data);
      end
      void'(q.pop_front());
    end else begin
      n_mis++;
      $display("FAIL unexpected_%s at cycle %0d: got event, required %s", ev_name(kind), cyc,
               (q.size() > 0) ? $sformatf("%s at cycle %0d", ev_name(q[0].kind), q[0].cyc) : "none");
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  logic kv_prev = 1'b0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL missed_%s: required at cycle %0d, got nothing by cycle %0d",
               ev_name(q[0].kind), q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (key_ack)                  observe(EV_ACK, '0);
    if (km_init)                  observe(EV_INIT, km_key);
    if (keys_valid && !kv_prev)   observe(EV_KV_RISE, '0);
    if (!keys_valid && kv_prev)   observe(EV_KV_FALL, '0);
    if (seq_err && !err_prev)     observe(EV_ERR_RISE, '0);
    if (!seq_err && err_prev)     observe(EV_ERR_FALL, '0);
    if (rd_vld_q)                 observe(EV_RD, rk_data);
    kv_prev  = keys_valid;
    err_prev = seq_err;
  end

  // expander model: streams one round key per cycle after km_init
  logic [127:0] ex_key;
  int           ex_md;
  int           ex_n;
  int           ex_r;
  initial begin
    km_round = '0;
    km_roundkey = '0;
    km_roundkey_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (km_init && reset_n) begin
        ex_key = km_key;
        ex_md  = mode;
        ex_n   = (ex_md == 2) ? 0 : (ex_md == 1) ? 3 : 11;
        for (int i = 0; i < ex_n; i++) begin
          @(negedge clk);
          if (!reset_n) break;
          ex_r = (ex_md == 1) ? skip_seq[i] : i;
          km_round          = 4'(ex_r);
          km_roundkey       = rk_of(ex_key, ex_r);
          km_roundkey_valid = 1'b1;
        end
        if (reset_n && ex_n > 0) @(negedge clk);
        km_roundkey_valid = 1'b0;
      end
    end
  end

  task automatic rd(input logic [3:0] a);
    rk_addr = a;
    rd_req  = 1'b1;
    push(EV_RD, cyc + 1, (a <= 4'd10) ? mem_mdl[a] : 128'h0);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_ack) return;
    end
    n_cmp++;
    n_mis++;
    $display("FAIL ack_timeout at cycle %0d: got no key_ack, required one", cyc);
  endtask

  task automatic load_key(input logic [127:0] k, input int md, input int busy, input int d);
    km_ready    = (d == 0);
    key_in      = k;
    key_req     = 1'b1;
    cipher_busy = (busy > 0);
    mode        = md;
    repeat (busy) @(negedge clk);
    cipher_busy = 1'b0;
    push_load(cyc, k, md, d);
    wait_ack();
    key_req = 1'b0;
    if (d > 0) begin
      repeat (d) @(negedge clk);
      km_ready = 1'b1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout at cycle %0d: got %0d events outstanding, required 0", cyc, q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout at cycle %0d: got no finish, required finish", cyc);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    key_in = '0;
    key_req = 1'b0;
    cipher_busy = 1'b0;
    km_ready = 1'b1;
    rk_addr = '0;
    for (int r = 0; r <= 10; r++) mem_mdl[r] = '0;
    repeat (3) @(negedge clk);
    chk("reset_key_ack", {127'h0, key_ack}, 128'h0);
    chk("reset_km_init", {127'h0, km_init}, 128'h0);
    chk("reset_km_key", km_key, 128'h0);
    chk("reset_rk_data", rk_data, 128'h0);
    chk("reset_keys_valid", {127'h0, keys_valid}, 128'h0);
    chk("reset_seq_err", {127'h0, seq_err}, 128'h0);
    reset_n = 1'b1;
    @(negedge clk);
    rd(4'd0);

    // nominal FIPS-197 load
    load_key(FIPS_KEY, 0, 0, 0);
    wait_done();
    rd(4'd10);
    rd(4'd0);
    rd(4'd5);

    // request held under cipher_busy, old keys stay valid
    load_key(128'h000102030405060708090a0b0c0d0e0f, 0, 20, 0);
    wait_done();
    rd(4'd0);
    rd(4'd10);

    // expander not ready for 5 cycles
    load_key(128'h3243f6a8885a308d313198a2e0370734, 0, 0, 5);
    wait_done();
    rd(4'd7);

    // out-of-order stream 0,1,3
    load_key(128'hffeeddccbbaa99887766554433221100, 1, 0, 0);
    wait_done();
    rd(4'd1);
    rd(4'd2);

    // silent expander trips the watchdog
    load_key(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 2, 0, 0);
    wait_done();

    // second request during CAPTURE waits for IDLE
    load_key(128'h11112222333344445555666677778888, 0, 0, 0);
    repeat (4) @(negedge clk);
    key_in  = 128'h9999aaaabbbbccccddddeeeeffff0000;
    key_req = 1'b1;
    push_load(last_t0 + 14, 128'h9999aaaabbbbccccddddeeeeffff0000, 0, 0);
    wait_ack();
    key_req = 1'b0;
    wait_done();
    rd(4'd15);
    rd(4'd3);

    // reset in the middle of a load
    load_key(128'h5555aaaa5555aaaa5555aaaa5555aaaa, 3, 0, 0);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midload_key_ack", {127'h0, key_ack}, 128'h0);
    chk("midload_km_init", {127'h0, km_init}, 128'h0);
    chk("midload_km_key", km_key, 128'h0);
    chk("midload_rk_data", rk_data, 128'h0);
    chk("midload_keys_valid", {127'h0, keys_valid}, 128'h0);
    chk("midload_seq_err", {127'h0, seq_err}, 128'h0);
    for (int r = 0; r <= 10; r++) mem_mdl[r] = '0;
    mdl_kv  = 1'b0;
    mdl_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(4'd0);
    rd(4'd10);
    wait_done();
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
